maze_walker: RTL and testbench
==============================

Name: maze_walker

Overview:
- Consumer of the carver's 16x16 maze bitmap (bit index x + 16*y; 1 = open path, 0 = wall).
- On start, snapshots the bitmap and walks it from a start cell to a goal cell using the right-hand wall-follower rule, one cell per clock.
- Publishes its live position, heading and step count for display logic, and flags success or failure.
- Sits between the carver's maze_data/finish outputs and the display/game FSM.

Parameters:
MAX_STEPS, 1023, step budget; the walk fails when step_count reaches this value without the goal being reached.
STEP_W, 10, width of step_count; must satisfy 2^STEP_W > MAX_STEPS.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin a walk; sampled only in IDLE, DONE or FAIL
maze_ready  in  1  carver finished flag; start is ignored while this is 0
maze_data  in  256  maze bitmap, bit x+16*y, 1 = open
start_x, start_y  in  4 each  start cell coordinates
goal_x, goal_y  in  4 each  goal cell coordinates
curr_x, curr_y  out  4 each  current walker cell
heading  out  2  0=N (y-1), 1=E (x+1), 2=S (y+1), 3=W (x-1)
step_count  out  STEP_W  moves taken in the current walk
busy  out  1  high while in the WALK state
done  out  1  goal reached; held until the next accepted start or rst
fail  out  1  walk aborted; held until the next accepted start or rst
trail_data  out  256  visited-cell map (see Optional Feature)

Behaviour:
- Reset values (rst high at a clock edge): state=IDLE; curr_x=curr_y=0; heading=0; step_count=0; busy=done=fail=0; trail_data=0; snapshot=0. Reset mid-walk aborts the walk immediately with no done or fail pulse.
- States: IDLE, WALK, DONE, FAIL.
- Start acceptance: in IDLE, DONE or FAIL, a cycle with start=1 and maze_ready=1 does all of the following at that edge:
  - snapshot <= maze_data; curr <= start; heading <= 1 (E); step_count <= 0;
  - done <= 0; fail <= 0;
  - state <= WALK, so busy is high from the next cycle.
  - start while in WALK is ignored. start with maze_ready=0 is ignored and outputs are unchanged.
- WALK evaluates one rule per cycle, in this priority order, against the snapshot:
  1. Current cell closed (snapshot bit 0) -> FAIL. Applies to the first WALK cycle when the start cell is a wall.
  2. curr == goal -> DONE. step_count is not incremented. start == goal gives DONE with step_count=0 one cycle after acceptance.
  3. step_count == MAX_STEPS -> FAIL.
  4. Otherwise choose the first open neighbour from the candidates right (h+1), forward (h), left (h+3), back (h+2), all mod 4. Then:
     - curr moves one cell in that direction;
     - heading <= that direction;
     - step_count increments by 1.
  5. No open neighbour (isolated cell) -> FAIL.
- Neighbour rules:
  - Neighbours outside 0..15 on either axis are walls. There is no wrap-around: x=15 going E and x=0 going W are closed, and the same holds for y.
  - Index arithmetic uses at least 9 bits so that x+16*y never aliases.
- Latency: exactly one move per clock. A path of N cells to the goal gives DONE N+1 cycles after acceptance, with step_count=N.
- In DONE and FAIL, curr, heading and step_count hold their final values.
- maze_data changes during WALK have no effect, because the walk uses the snapshot only.

Optional Feature:
MAZE_WALKER_TRAIL_EN
- Defined:
  - trail_data clears to 0 at start acceptance and then sets the start cell bit.
  - Each move sets the destination cell bit; bits are never cleared during a walk.
  - trail_data holds after DONE or FAIL until the next acceptance or rst.
- Not defined: trail_data is constant 0 and no trail register is synthesised.

Test Plan:
- Corridor: row y=0 open for x=0..5, all other cells closed; start (0,0), goal (5,0), start pulse -> DONE 6 cycles after acceptance, step_count=5, curr=(5,0), heading=1, fail=0.
- Dead-end bounce: only (0,0),(1,0),(2,0) open; start (0,0), goal (0,0)... use goal (15,15) instead -> walker goes to (2,0), turns back to W, returns to (0,0), oscillates; with MAX_STEPS=8 -> FAIL when step_count=8, done=0.
- Edge no-wrap: only column x=15 open for y=0..3 plus (0,0); start (15,0), goal (15,3) -> never visits x=0; DONE with step_count=3, heading=2.
- Closed start: start (3,3) with bit 51=0 -> fail=1 on the first WALK cycle, step_count=0.
- Handshake and reset:
  - start with maze_ready=0 -> busy stays 0.
  - start during WALK -> ignored and the walk completes.
  - rst asserted mid-walk -> next cycle: IDLE, all outputs at their reset values.
- Trail (macro defined): corridor test -> trail_data bits 0..5 =1, all others 0. Macro undefined -> trail_data=0 throughout.

Source files
------------

// File: rtl/maze_walker.sv
// maze_walker: right-hand wall follower over a snapshot of a 16x16 maze bitmap
// (bit x+16*y, 1 = open). One move per clock; reports position, heading,
// step count and a done/fail verdict.
// Optional visited-cell map: define MAZE_WALKER_TRAIL_EN to enable trail_data.
module maze_walker #(
    parameter int unsigned MAX_STEPS = 1023,
    parameter int unsigned STEP_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              maze_ready,
    input  logic [255:0]      maze_data,
    input  logic [3:0]        start_x,
    input  logic [3:0]        start_y,
    input  logic [3:0]        goal_x,
    input  logic [3:0]        goal_y,
    output logic [3:0]        curr_x,
    output logic [3:0]        curr_y,
    output logic [1:0]        heading,
    output logic [STEP_W-1:0] step_count,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [255:0]      trail_data
);

    typedef enum logic [1:0] {StIdle, StWalk, StDone, StFail} state_e;

    state_e       state;
    logic [255:0] snapshot;

    logic [3:0] nb_open;   // indexed by absolute direction 0=N 1=E 2=S 3=W
    logic       found;
    logic [1:0] mv_dir;
    logic [1:0] cand;
    logic [3:0] nx;
    logic [3:0] ny;
    logic       cur_open;
    logic       at_goal;
    logic       at_limit;
    logic       accept;
    logic       do_move;

    // Index is formed at 9 bits so x+16*y can never wrap onto another cell.
    function automatic logic cell_open(input logic [255:0] m, input logic [3:0] x,
                                       input logic [3:0] y);
        logic [8:0] idx;
        idx = {5'd0, x} + {1'b0, y, 4'd0};
        return (idx < 9'd256) && m[idx[7:0]];
    endfunction

    assign cur_open = cell_open(snapshot, curr_x, curr_y);
    assign at_goal  = (curr_x == goal_x) && (curr_y == goal_y);
    assign at_limit = (step_count == STEP_W'(MAX_STEPS));
    assign accept   = (state != StWalk) && start && maze_ready;
    assign do_move  = (state == StWalk) && cur_open && !at_goal && !at_limit && found;

    // Open-ness of the four neighbours; off-grid cells count as walls.
    always_comb begin
        nb_open[0] = (curr_y != 4'd0)  && cell_open(snapshot, curr_x, curr_y - 4'd1);
        nb_open[1] = (curr_x != 4'd15) && cell_open(snapshot, curr_x + 4'd1, curr_y);
        nb_open[2] = (curr_y != 4'd15) && cell_open(snapshot, curr_x, curr_y + 4'd1);
        nb_open[3] = (curr_x != 4'd0)  && cell_open(snapshot, curr_x - 4'd1, curr_y);
    end

    // Pick the first open direction in order right, forward, left, back.
    // Relative offsets 1,0,3,2 are exactly k ^ 1 for k = 0..3.
    always_comb begin
        found  = 1'b0;
        mv_dir = heading;
        cand   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = heading + (2'(k) ^ 2'b01);
            if (!found && nb_open[cand]) begin
                found  = 1'b1;
                mv_dir = cand;
            end
        end
    end

    // Destination cell for the chosen direction.
    always_comb begin
        nx = curr_x;
        ny = curr_y;
        unique case (mv_dir)
            2'd0: ny = curr_y - 4'd1;
            2'd1: nx = curr_x + 4'd1;
            2'd2: ny = curr_y + 4'd1;
            2'd3: nx = curr_x - 4'd1;
        endcase
    end

    // Walker FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            snapshot   <= '0;
            curr_x     <= 4'd0;
            curr_y     <= 4'd0;
            heading    <= 2'd0;
            step_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            case (state)
                StWalk: begin
                    if (!cur_open || (!at_goal && (at_limit || !found))) begin
                        state <= StFail;
                        busy  <= 1'b0;
                        fail  <= 1'b1;
                    end else if (at_goal) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        curr_x     <= nx;
                        curr_y     <= ny;
                        heading    <= mv_dir;
                        step_count <= step_count + STEP_W'(1);
                    end
                end
                default: begin
                    if (accept) begin
                        state      <= StWalk;
                        snapshot   <= maze_data;
                        curr_x     <= start_x;
                        curr_y     <= start_y;
                        heading    <= 2'd1;
                        step_count <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef MAZE_WALKER_TRAIL_EN
    // Visited-cell map: seeded with the start cell, grows with each move.
    always_ff @(posedge clk) begin
        if (rst) begin
            trail_data <= '0;
        end else if (accept) begin
            trail_data <= 256'd1 << {start_y, start_x};
        end else if (do_move) begin
            trail_data[{ny, nx}] <= 1'b1;
        end
    end
`else
    assign trail_data = '0;
    logic unused_move;
    assign unused_move = do_move;
`endif

endmodule

// File: tb/tb_maze_walker.sv
// Scoreboard bench for maze_walker: stimulus pushes model predictions, a
// monitor pops them when a walk ends (busy falls with done or fail).
module tb_maze_walker;

    localparam int MAX_STEPS = 8;
    localparam int STEP_W    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              maze_ready;
    logic [255:0]      maze_data;
    logic [3:0]        start_x, start_y, goal_x, goal_y;
    logic [3:0]        curr_x, curr_y;
    logic [1:0]        heading;
    logic [STEP_W-1:0] step_count;
    logic              busy, done, fail;
    logic [255:0]      trail_data;

    maze_walker #(.MAX_STEPS(MAX_STEPS), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .maze_ready (maze_ready),
        .maze_data  (maze_data),
        .start_x    (start_x),
        .start_y    (start_y),
        .goal_x     (goal_x),
        .goal_y     (goal_y),
        .curr_x     (curr_x),
        .curr_y     (curr_y),
        .heading    (heading),
        .step_count (step_count),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .trail_data (trail_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           dn;
        bit           fl;
        int           x;
        int           y;
        int           h;
        int           steps;
        logic [255:0] trail;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_open(input logic [255:0] m, input int x, input int y);
        if (x < 0 || x > 15 || y < 0 || y > 15) return 1'b0;
        return m[x + 16 * y];
    endfunction

    // Reference walk: plain coordinate stepping with direction tables.
    function automatic exp_t model(input logic [255:0] m, input int sx, input int sy,
                                   input int gx, input int gy);
        exp_t e;
        int x, y, h, nx, ny, d;
        bit moved;
        int dx[4]  = '{0, 1, 0, -1};
        int dy[4]  = '{-1, 0, 1, 0};
        int rel[4] = '{1, 0, 3, 2};
        x = sx; y = sy; h = 1;
        e.dn = 0; e.fl = 0; e.steps = 0;
        e.trail = '0;
        e.trail[x + 16 * y] = 1'b1;
        while (1) begin
            if (!is_open(m, x, y)) begin e.fl = 1; break; end
            if (x == gx && y == gy) begin e.dn = 1; break; end
            if (e.steps == MAX_STEPS) begin e.fl = 1; break; end
            moved = 0;
            for (int r = 0; r < 4 && !moved; r++) begin
                d  = (h + rel[r]) % 4;
                nx = x + dx[d];
                ny = y + dy[d];
                if (is_open(m, nx, ny)) begin
                    x = nx; y = ny; h = d;
                    e.steps++;
                    e.trail[x + 16 * y] = 1'b1;
                    moved = 1;
                end
            end
            if (!moved) begin e.fl = 1; break; end
        end
        e.x = x; e.y = y; e.h = h;
`ifndef MAZE_WALKER_TRAIL_EN
        e.trail = '0;
`endif
        return e;
    endfunction

    // Monitor: a walk ends when busy falls; compare against the oldest prediction.
    initial begin
        logic busy_prev;
        int   busy_cycles;
        exp_t e;
        busy_prev   = 1'b0;
        busy_cycles = 0;
        forever begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (busy_prev && !busy) begin
                if (done || fail) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_end: got done=%0b fail=%0b expected none",
                                 done, fail);
                    end else begin
                        e = sb.pop_front();
                        check("done", done, e.dn);
                        check("fail", fail, e.fl);
                        check("curr_x", curr_x, e.x);
                        check("curr_y", curr_y, e.y);
                        check("heading", heading, e.h);
                        check("step_count", step_count, e.steps);
                        check("walk_cycles", busy_cycles, e.steps + 1);
                        check("trail", trail_data, e.trail);
                    end
                end
                busy_cycles = 0;
            end
            busy_prev = busy;
        end
    end

    task automatic start_walk(input logic [255:0] m, input int sx, input int sy,
                              input int gx, input int gy, input bit push);
        @(posedge clk); #1;
        maze_data  = m;
        start_x    = 4'(sx); start_y = 4'(sy);
        goal_x     = 4'(gx); goal_y  = 4'(gy);
        start      = 1'b1;
        maze_ready = 1'b1;
        if (push) sb.push_back(model(m, sx, sy, gx, gy));
        @(posedge clk); #1;
        start     = 1'b0;
        maze_data = {8{$urandom}};   // walk must use the snapshot
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL walk_timeout: got busy=1 expected busy=0 within 200 cycles");
        end
        @(negedge clk); #1;
    endtask

    initial begin
        logic [255:0] m;
        int sx, sy, gx, gy;

        rst = 1'b1; start = 1'b0; maze_ready = 1'b0; maze_data = '0;
        start_x = 0; start_y = 0; goal_x = 0; goal_y = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_pos", {curr_y, curr_x}, 0);
        check("rst_heading", heading, 0);
        check("rst_steps", step_count, 0);
        check("rst_trail", trail_data, 0);
        rst = 1'b0;

        // Corridor along row 0, with an ignored start pulse mid-walk.
        start_walk(256'h3F, 0, 0, 5, 0, 1'b1);
        start = 1'b1; start_x = 4'd9; start_y = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // maze_ready low: start ignored, outputs hold the corridor result.
        @(posedge clk); #1;
        maze_data = '1; start = 1'b1; maze_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("noready_busy", busy, 0);
        check("noready_done", done, 1);
        check("noready_steps", step_count, 5);
        check("noready_x", curr_x, 5);

        // Dead end bounce until the step budget runs out.
        start_walk(256'h7, 0, 0, 15, 15, 1'b1);
        wait_idle();

        // Right edge column: no wrap-around to x=0.
        m = '0; m[0] = 1'b1; m[15] = 1'b1; m[31] = 1'b1; m[47] = 1'b1; m[63] = 1'b1;
        start_walk(m, 15, 0, 15, 3, 1'b1);
        wait_idle();

        // Closed start cell.
        m = {8{$urandom}}; m[51] = 1'b0;
        start_walk(m, 3, 3, 7, 7, 1'b1);
        wait_idle();

        // Start equals goal.
        start_walk('1, 4, 9, 4, 9, 1'b1);
        wait_idle();

        // Randomised walks on dense mazes with nearby goals.
        for (int t = 0; t < 40; t++) begin
            for (int w = 0; w < 8; w++) m[w*32 +: 32] = $urandom | $urandom;
            sx = $urandom_range(0, 15);
            sy = $urandom_range(0, 15);
            gx = (sx + $urandom_range(0, 3)) % 16;
            gy = (sy + $urandom_range(0, 3)) % 16;
            start_walk(m, sx, sy, gx, gy, 1'b1);
            wait_idle();
        end

        // Reset mid-walk aborts without a verdict.
        start_walk(256'h7, 0, 0, 15, 15, 1'b0);
        @(posedge clk); #1;
        check("midwalk_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_fail", fail, 0);
        check("abort_pos", {curr_y, curr_x}, 0);
        check("abort_heading", heading, 0);
        check("abort_steps", step_count, 0);
        check("abort_trail", trail_data, 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
